mul16_rr_sched: RTL and testbench

Round-robin scheduler that shares a single pipelined 16×16 unsigned multiplier (the `multiplier16b` reduction tree, wrapped in operand and product registers) between `NREQ` requesters. It accepts at most one operation per cycle, tags each operation with its requester index, and returns the 32-bit product into a per-requester response register. Each requester has its own valid/ready handshake and may have at most one operation outstanding. The block sits between the client units and the multiplier datapath.

---
 rtl/mul16_rr_sched.sv | 196 +++++++++++++++++++
 tb/tb_mul16_rr_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_rr_sched.sv
// mul16_rr_sched: round-robin arbiter sharing one pipelined 16x16 unsigned
// multiplier between NREQ requesters. Each requester may have one operation
// in flight; its product lands in a private response register.
module mul16_rr_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*32-1:0]   rsp_z,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Unsigned 16x16 product as a sum of shifted partial products.
    function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) acc = acc + ({16'd0, a} << i);
        end
        return acc;
    endfunction

    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_z_q [NREQ];
    logic [31:0]     rsp_z_d [NREQ];
    logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]     op_count_q, op_count_d;

    logic            op_vld_q, op_vld_d;
    logic [TW-1:0]   op_tag_q, op_tag_d;
    logic [15:0]     op_a_q, op_a_d;
    logic [15:0]     op_b_q, op_b_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [TW-1:0]   grant_idx;
    logic            found;
    logic [TW:0]     scan_sum;
    logic [TW-1:0]   scan_idx;
    logic [31:0]     prod;

    logic            fin_vld;
    logic [TW-1:0]   fin_tag;
    logic [31:0]     fin_z;

    logic [NREQ-1:0] consume;
    logic [15:0]     done_inc;

    assign elig = req_valid & ~pending_q;

    // Grant the first eligible requester scanning upward from rr_ptr with wrap.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (TW+1)'(k);
            if (scan_sum >= (TW+1)'(NREQ)) scan_sum = scan_sum - (TW+1)'(NREQ);
            scan_idx = scan_sum[TW-1:0];
            if (!found && elig[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (!rst_n) found = 1'b0;
        grant = found ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end

    assign req_ready = grant;

    // Capture the granted operands and advance the round-robin pointer.
    always_comb begin
        op_vld_d = found;
        op_tag_d = op_tag_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            op_tag_d = grant_idx;
            op_a_d   = req_a[{grant_idx, 4'b0000} +: 16];
            op_b_d   = req_b[{grant_idx, 4'b0000} +: 16];
            rr_ptr_d = (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + TW'(1);
        end
    end

    assign prod = mul16(op_a_q, op_b_q);

    generate
        if (LAT == 1) begin : g_direct
            assign fin_vld = op_vld_q;
            assign fin_tag = op_tag_q;
            assign fin_z   = prod;
        end else begin : g_pipe
            logic [LAT-2:0] stg_vld_q, stg_vld_d;
            logic [TW-1:0]  stg_tag_q [LAT-1];
            logic [TW-1:0]  stg_tag_d [LAT-1];
            logic [31:0]    stg_z_q   [LAT-1];
            logic [31:0]    stg_z_d   [LAT-1];

            // Shift valid/tag/product down the product pipeline.
            always_comb begin
                stg_vld_d[0] = op_vld_q;
                stg_tag_d[0] = op_tag_q;
                stg_z_d[0]   = prod;
                for (int k = 1; k < LAT-1; k++) begin
                    stg_vld_d[k] = stg_vld_q[k-1];
                    stg_tag_d[k] = stg_tag_q[k-1];
                    stg_z_d[k]   = stg_z_q[k-1];
                end
            end

            // Pipeline valids are cleared by reset so in-flight work is dropped.
            always_ff @(posedge clk) begin
                if (!rst_n) stg_vld_q <= '0;
                else        stg_vld_q <= stg_vld_d;
            end

            // Pipeline tag/product payload carries no reset.
            always_ff @(posedge clk) begin
                for (int k = 0; k < LAT-1; k++) begin
                    stg_tag_q[k] <= stg_tag_d[k];
                    stg_z_q[k]   <= stg_z_d[k];
                end
            end

            assign fin_vld = stg_vld_q[LAT-2];
            assign fin_tag = stg_tag_q[LAT-2];
            assign fin_z   = stg_z_q[LAT-2];
        end
    endgenerate

    // Response registers, pending flags and completion counter.
    always_comb begin
        consume     = rsp_valid_q & rsp_ready;
        rsp_valid_d = rsp_valid_q & ~consume;
        for (int i = 0; i < NREQ; i++) rsp_z_d[i] = rsp_z_q[i];
        if (fin_vld) begin
            rsp_valid_d[fin_tag] = 1'b1;
            rsp_z_d[fin_tag]     = fin_z;
        end
        pending_d = (pending_q & ~consume) | grant;
        done_inc  = '0;
        for (int i = 0; i < NREQ; i++) done_inc = done_inc + {15'd0, consume[i]};
        op_count_d = op_count_q + done_inc;
    end

    // Control and response state; operand payload holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            rsp_valid_q <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
            op_vld_q    <= 1'b0;
            for (int i = 0; i < NREQ; i++) rsp_z_q[i] <= '0;
        end else begin
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
            op_vld_q    <= op_vld_d;
            for (int i = 0; i < NREQ; i++) rsp_z_q[i] <= rsp_z_d[i];
        end
    end

    // Operand register payload.
    always_ff @(posedge clk) begin
        op_tag_q <= op_tag_d;
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp_pack
            assign rsp_z[32*gi +: 32] = rsp_z_q[gi];
        end
    endgenerate

    assign rsp_valid = rsp_valid_q;
    assign busy      = |pending_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul16_rr_sched.sv
// Directed bench for mul16_rr_sched (NREQ=4, LAT=2).
module tb_mul16_rr_sched;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [127:0] rsp_z;
    logic         busy;
    logic [15:0]  op_count;

    int n_checks;
    int n_fail;
    int issued;
    int cyc;
    int ogr;

    mul16_rr_sched #(.NREQ(4), .LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setab(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    function automatic logic [31:0] zof(input int i);
        return rsp_z[32*i +: 32];
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;

        // reset state
        tick();
        tick();
        req_valid = 4'hF;
        #1 check("rst_req_ready", req_ready, 4'h0);
        tick();
        check("rst_rsp_valid", rsp_valid, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_op_count", op_count, 16'h0);
        for (int i = 0; i < 4; i++) check("rst_rsp_z", zof(i), 32'h0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // single op on requester 2
        setab(2, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        #1 check("t1_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("t1_busy_e1", busy, 1'b1);
        check("t1_rspv_e1", rsp_valid, 4'h0);
        tick();
        check("t1_rspv_e2", rsp_valid, 4'h0);
        check("t1_busy_e2", busy, 1'b1);
        tick();
        check("t1_rspv_e3", rsp_valid, 4'b0100);
        check("t1_z", zof(2), 32'hFFFE0001);
        check("t1_cnt0", op_count, 16'd0);
        check("t1_busy_e3", busy, 1'b1);
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
        check("t1_rspv_done", rsp_valid, 4'h0);
        check("t1_busy_done", busy, 1'b0);
        check("t1_cnt1", op_count, 16'd1);
        check("t1_z_hold", zof(2), 32'hFFFE0001);

        // round robin with all requesters valid
        pulse_reset();
        tick();
        check("rr_cnt_reset", op_count, 16'd0);
        for (int i = 0; i < 4; i++) setab(i, 16'(i + 1), 16'h0100);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_grant", req_ready, 64'(4'b0001 << (k % 4)));
            if (k == 3) begin
                check("rr_r0_held", rsp_valid[0], 1'b1);
                check("rr_r0_not_regrant", req_ready[0], 1'b0);
                check("rr_z0", zof(0), 32'h100);
            end
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) tick();
        check("rr_cnt8", op_count, 16'd8);
        check("rr_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) check("rr_z", zof(i), 64'((i + 1) * 256));

        // backpressure on requester 1
        setab(1, 16'h0003, 16'h0100);
        rsp_ready = 4'b1101;
        req_valid = 4'hF;
        ogr = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (c == 0) check("bp_grant0", req_ready, 4'b0001);
            if (c == 1) check("bp_grant1", req_ready, 4'b0010);
            if (c >= 2) begin
                check("bp_ready1_low", req_ready[1], 1'b0);
                if ((req_ready & 4'b1101) != 4'b0000) ogr++;
            end
            if (c >= 4) begin
                check("bp_rspv1", rsp_valid[1], 1'b1);
                check("bp_z1_stable", zof(1), 32'h300);
            end
            tick();
        end
        check("bp_others_served", 64'(ogr >= 12), 64'd1);
        req_valid = '0;
        rsp_ready = 4'hF;
        for (int k = 0; k < 6; k++) tick();
        check("bp_drain_busy", busy, 1'b0);
        check("bp_drain_rspv", rsp_valid, 4'h0);

        // simultaneous completion
        pulse_reset();
        rsp_ready = '0;
        setab(0, 16'h1234, 16'h0010);
        setab(2, 16'hABCD, 16'h0002);
        req_valid = 4'b0101;
        #1 check("sim_grant0", req_ready, 4'b0001);
        tick();
        #1 check("sim_grant2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) tick();
        check("sim_rspv", rsp_valid, 4'b0101);
        check("sim_cnt0", op_count, 16'd0);
        check("sim_z0", zof(0), 32'h00012340);
        check("sim_z2", zof(2), 32'h0001579A);
        rsp_ready = 4'b0101;
        tick();
        rsp_ready = '0;
        check("sim_cnt2", op_count, 16'd2);
        check("sim_rspv_clr", rsp_valid, 4'h0);
        check("sim_busy", busy, 1'b0);

        // reset mid-flight: pointer is at 3 after the last grant to 2
        for (int i = 0; i < 4; i++) setab(i, 16'h0011, 16'h0022);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        #1 check("mf_grant3", req_ready, 4'b1000);
        tick();
        #1 check("mf_grant0", req_ready, 4'b0001);
        tick();
        #1 check("mf_grant1", req_ready, 4'b0010);
        tick();
        rst_n = 1'b0;
        #1 check("mf_ready_in_rst", req_ready, 4'h0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        check("mf_rspv", rsp_valid, 4'h0);
        check("mf_busy", busy, 1'b0);
        check("mf_cnt", op_count, 16'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mf_no_stale", rsp_valid, 4'h0);
            check("mf_cnt_stay", op_count, 16'd0);
        end
        req_valid = 4'hF;
        #1 check("mf_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        for (int k = 0; k < 5; k++) tick();

        // op_count wrap
        pulse_reset();
        rsp_ready = 4'hF;
        issued = 0;
        cyc = 0;
        while (issued < 65535 && cyc < 70000) begin
            req_valid = 4'hF;
            #1;
            if ((req_valid & req_ready) != 4'b0000) issued++;
            tick();
            cyc++;
        end
        req_valid = '0;
        check("wrap_issued", 64'(issued), 64'd65535);
        for (int k = 0; k < 6; k++) tick();
        check("wrap_cnt_max", op_count, 16'hFFFF);
        req_valid = 4'b0001;
        #1 check("wrap_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        check("wrap_cnt_zero", op_count, 16'h0000);
        check("wrap_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
